// File: rtl/rom_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_prog_loader_if
// Description : Byte-stream valid/ready channel feeding the ROM program
//               loader. A transfer happens on a rising clock edge where
//               valid and ready are both high.
//   valid  : source has a byte on data
//   data   : stream byte [7:0]
//   ready  : sink accepts the byte this cycle
// Modports    : master = byte source, slave = loader
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_prog_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/rom_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_prog_loader
// Description : Receives a framed byte stream (SYNC, LEN_LO, LEN_HI, 4*N
//               little-endian data bytes, XOR checksum) and writes 32-bit
//               words into the instruction ROM write port. The CPU is held
//               in reset until a frame loads with a good checksum.
// Ports       :
//   clk          : system clock, rising edge
//   rst_n        : asynchronous reset, active low
//   s_in         : byte stream channel (slave side)
//   i_rearm      : pulse, leaves DONE/ERR back to IDLE
//   o_rom_we     : single-cycle ROM write strobe
//   o_rom_waddr  : ROM word address [ADDR_W-1:0]
//   o_rom_wdata  : ROM write word [31:0]
//   o_cpu_hold   : 1 keeps the core in reset
//   o_done       : frame loaded, checksum good
//   o_err        : frame rejected (oversize length or bad checksum)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_prog_loader #(
  parameter int         ADDR_W = 12,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  rom_prog_loader_if.slave       s_in,
  input  wire logic              i_rearm,
  output logic                   o_rom_we,
  output logic [ADDR_W-1:0]      o_rom_waddr,
  output logic [31:0]            o_rom_wdata,
  output logic                   o_cpu_hold,
  output logic                   o_done,
  output logic                   o_err
);

  // ROM capacity in words, expressed at 17 bits so a 16-bit length can be
  // compared against it without overflow.
  localparam logic [16:0] c_DEPTH = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [7:0]          r_len_lo;
  logic [15:0]         r_len;
  logic [1:0]          r_byte_idx;
  logic [ADDR_W:0]     r_word_cnt;
  logic [23:0]         r_shift;     // first three bytes of the word in flight
  logic [7:0]          r_csum;
  logic                r_rom_we;
  logic [ADDR_W-1:0]   r_rom_waddr;
  logic [31:0]         r_rom_wdata;

  logic                w_ready;
  logic                w_xfer;
  logic                w_rearm;
  logic [15:0]         w_len;
  logic [31:0]         w_word;
  logic [ADDR_W:0]     w_cnt_inc;
  logic                w_last_word;

  // Ready depends on state only, never on valid.
  assign w_ready     = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_xfer      = s_in.valid && w_ready;
  assign w_rearm     = i_rearm && !w_ready;
  assign w_len       = {s_in.data, r_len_lo};
  assign w_word      = {s_in.data, r_shift};
  assign w_cnt_inc   = r_word_cnt + (ADDR_W+1)'(1);
  assign w_last_word = (17'(w_cnt_inc) == {1'b0, r_len});

  assign s_in.ready  = w_ready;
  assign o_rom_we    = r_rom_we;
  assign o_rom_waddr = r_rom_waddr;
  assign o_rom_wdata = r_rom_wdata;
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_ERR);
  assign o_cpu_hold  = (r_state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && (s_in.data == SYNC)) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_xfer) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          if ({1'b0, w_len} > c_DEPTH) w_state_nxt = S_ERR;
          else if (w_len == 16'd0)     w_state_nxt = S_CSUM;
          else                         w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer && (r_byte_idx == 2'd3) && w_last_word) w_state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (w_xfer) w_state_nxt = (s_in.data == r_csum) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (i_rearm) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_lo    <= '0;
      r_len       <= '0;
      r_byte_idx  <= '0;
      r_word_cnt  <= '0;
      r_shift     <= '0;
      r_csum      <= '0;
      r_rom_we    <= 1'b0;
      r_rom_waddr <= '0;
      r_rom_wdata <= '0;
    end else begin
      r_rom_we <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          S_IDLE: begin
            // A new frame always starts from address 0 with a clean checksum.
            if (s_in.data == SYNC) begin
              r_byte_idx <= '0;
              r_word_cnt <= '0;
              r_csum     <= '0;
            end
          end
          S_LEN_LO: r_len_lo <= s_in.data;
          S_LEN_HI: r_len    <= w_len;
          S_DATA: begin
            r_csum     <= r_csum ^ s_in.data;
            r_shift    <= {s_in.data, r_shift[23:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_rom_we    <= 1'b1;
              r_rom_waddr <= r_word_cnt[ADDR_W-1:0];
              r_rom_wdata <= w_word;
              r_word_cnt  <= w_cnt_inc;
            end
          end
          default: ;
        endcase
      end else if (w_rearm) begin
        r_byte_idx <= '0;
        r_word_cnt <= '0;
        r_shift    <= '0;
        r_csum     <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_prog_loader
// Description : Directed self-checking bench for rom_prog_loader. One
//               instance uses the default 12-bit address, a second uses a
//               16-word ROM for the length boundary cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rearm, rearm4;
  logic        rom_we, rom_we4;
  logic [11:0] waddr;
  logic [3:0]  waddr4;
  logic [31:0] wdata, wdata4;
  logic        hold, done, err;
  logic        hold4, done4, err4;

  rom_prog_loader_if bus  ();
  rom_prog_loader_if bus4 ();

  rom_prog_loader #(.ADDR_W(12), .SYNC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(bus), .i_rearm(rearm),
    .o_rom_we(rom_we), .o_rom_waddr(waddr), .o_rom_wdata(wdata),
    .o_cpu_hold(hold), .o_done(done), .o_err(err)
  );

  rom_prog_loader #(.ADDR_W(4), .SYNC(8'hA5)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_in(bus4), .i_rearm(rearm4),
    .o_rom_we(rom_we4), .o_rom_waddr(waddr4), .o_rom_wdata(wdata4),
    .o_cpu_hold(hold4), .o_done(done4), .o_err(err4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitors, sampled on the falling edge.
  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wr4_cnt = 0;
  logic [3:0]  wa4_last = '0;
  logic [31:0] wd4_last = '0;

  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
    if (rom_we4 === 1'b1) begin
      wr4_cnt++;
      wa4_last = waddr4;
      wd4_last = wdata4;
    end
  end

  // Entered and left on a falling edge; the byte transfers on the rising
  // edge in between.
  task automatic send(input int sel, input logic [7:0] b, input int gap);
    int   budget;
    logic rdy;
    for (int i = 0; i < gap; i++) begin
      if (sel == 1) bus4.valid = 1'b0; else bus.valid = 1'b0;
      @(negedge clk);
    end
    if (sel == 1) begin bus4.valid = 1'b1; bus4.data = b; end
    else          begin bus.valid  = 1'b1; bus.data  = b; end
    budget = 20;
    rdy = (sel == 1) ? bus4.ready : bus.ready;
    while (rdy !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
      rdy = (sel == 1) ? bus4.ready : bus.ready;
    end
    if (budget == 0) check_val("ready_timeout", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    if (sel == 1) bus4.valid = 1'b0; else bus.valid = 1'b0;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] fr[$], input int maxgap);
    foreach (fr[i]) send(sel, fr[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic pulse_rearm(input int sel);
    if (sel == 1) rearm4 = 1'b1; else rearm = 1'b1;
    @(negedge clk);
    if (sel == 1) rearm4 = 1'b0; else rearm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fr[$];
    rst_n  = 1'b0;
    rearm  = 1'b0;
    rearm4 = 1'b0;
    bus.valid  = 1'b0; bus.data  = 8'h00;
    bus4.valid = 1'b0; bus4.data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_ready", {31'd0, bus.ready}, 32'd1);
    check_val("rst_we",    {31'd0, rom_we},    32'd0);
    check_val("rst_waddr", {20'd0, waddr},     32'd0);
    check_val("rst_wdata", wdata,              32'd0);
    check_val("rst_hold",  {31'd0, hold},      32'd1);
    check_val("rst_done",  {31'd0, done},      32'd0);
    check_val("rst_err",   {31'd0, err},       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 16-word ROM: N=17 rejected right after LEN_HI
    fr = {8'hA5, 8'h11, 8'h00};
    send_frame(1, fr, 0);
    check_val("n17_err",   {31'd0, err4},       32'd1);
    check_val("n17_ready", {31'd0, bus4.ready}, 32'd0);
    check_val("n17_hold",  {31'd0, hold4},      32'd1);
    check_val("n17_wr",    wr4_cnt,             32'd0);
    pulse_rearm(1);
    check_val("rearm4_err", {31'd0, err4}, 32'd0);

    // N=0: straight to checksum 0x00
    fr = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1, fr, 0);
    check_val("n0_done", {31'd0, done4}, 32'd1);
    check_val("n0_hold", {31'd0, hold4}, 32'd0);
    check_val("n0_wr",   wr4_cnt,        32'd0);
    pulse_rearm(1);

    // N=16 fills the ROM exactly; bytes 0..63, XOR of them is 0x00
    fr = {8'hA5, 8'h10, 8'h00};
    for (int i = 0; i < 64; i++) fr.push_back(8'(i));
    fr.push_back(8'h00);
    send_frame(1, fr, 0);
    check_val("n16_done",  {31'd0, done4},    32'd1);
    check_val("n16_wr",    wr4_cnt,           32'd16);
    check_val("n16_waddr", {28'd0, wa4_last}, 32'd15);
    check_val("n16_wdata", wd4_last,          32'h3F3E3D3C);

    // Two-word frame, checksum 13^93^10 = 0x90
    wa_q.delete(); wd_q.delete();
    fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(0, fr, 0);
    check_val("a_done",  {31'd0, done},      32'd1);
    check_val("a_hold",  {31'd0, hold},      32'd0);
    check_val("a_err",   {31'd0, err},       32'd0);
    check_val("a_ready", {31'd0, bus.ready}, 32'd0);
    check_val("a_nwr",   wa_q.size(),        32'd2);
    if (wa_q.size() == 2) begin
      check_val("a_addr0", {20'd0, wa_q[0]}, 32'd0);
      check_val("a_data0", wd_q[0],          32'h00000013);
      check_val("a_addr1", {20'd0, wa_q[1]}, 32'd1);
      check_val("a_data1", wd_q[1],          32'h00100093);
    end

    // Rearm with a byte offered in the same cycle: byte must be refused
    rearm = 1'b1; bus.valid = 1'b1; bus.data = 8'hA5;
    check_val("rearm_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    rearm = 1'b0; bus.valid = 1'b0;
    check_val("rearm_done",  {31'd0, done},      32'd0);
    check_val("rearm_hold",  {31'd0, hold},      32'd1);
    check_val("rearm_ready2",{31'd0, bus.ready}, 32'd1);

    // Junk then a one-word frame with random gaps; checksum EF^BE^AD^DE = 0x22
    wa_q.delete(); wd_q.delete();
    fr = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_frame(0, fr, 3);
    check_val("b_done", {31'd0, done}, 32'd1);
    check_val("b_hold", {31'd0, hold}, 32'd0);
    check_val("b_nwr",  wa_q.size(),   32'd1);
    if (wa_q.size() == 1) begin
      check_val("b_addr", {20'd0, wa_q[0]}, 32'd0);
      check_val("b_data", wd_q[0],          32'hDEADBEEF);
    end
    pulse_rearm(0);

    // Same two-word frame with a bad checksum
    wa_q.delete(); wd_q.delete();
    fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    send_frame(0, fr, 0);
    check_val("c_err",   {31'd0, err},       32'd1);
    check_val("c_done",  {31'd0, done},      32'd0);
    check_val("c_hold",  {31'd0, hold},      32'd1);
    check_val("c_ready", {31'd0, bus.ready}, 32'd0);
    check_val("c_nwr",   wa_q.size(),        32'd2);
    pulse_rearm(0);
    check_val("c_rearm_err", {31'd0, err}, 32'd0);

    // Reset in the middle of word 1
    wa_q.delete(); wd_q.delete();
    fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_frame(0, fr, 0);
    check_val("d_we_lat",  {31'd0, rom_we}, 32'd1);
    check_val("d_waddr",   {20'd0, waddr},  32'd0);
    check_val("d_wdata",   wdata,           32'h00000013);
    send(0, 8'h93, 0);
    check_val("d_we_pulse",{31'd0, rom_we}, 32'd0);
    check_val("d_hold_dat",wdata,           32'h00000013);
    send(0, 8'h00, 0);
    rst_n = 1'b0;
    #1;
    check_val("d_rst_wdata", wdata,              32'd0);
    check_val("d_rst_hold",  {31'd0, hold},      32'd1);
    check_val("d_rst_ready", {31'd0, bus.ready}, 32'd1);
    check_val("d_rst_we",    {31'd0, rom_we},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("d_nwr_partial", wa_q.size(), 32'd1);

    // Fresh frame after reset; checksum 78^56^34^12 = 0x08
    fr = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_frame(0, fr, 1);
    check_val("e_done", {31'd0, done}, 32'd1);
    check_val("e_hold", {31'd0, hold}, 32'd0);
    check_val("e_nwr",  wa_q.size(),   32'd2);
    if (wa_q.size() == 2) begin
      check_val("e_addr", {20'd0, wa_q[1]}, 32'd0);
      check_val("e_data", wd_q[1],          32'h12345678);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
